instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Reader side of the word-addressed, combinational-read instruction memory.
- Owns the program counter and drives the byte address. Captures the returned 32-bit instruction word into a 2-entry buffer.
- Presents the instruction, its PC and the split instruction fields to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute.

Parameters:
- DATA_WIDTH, 32, instruction/address width.
- MEM_DEPTH, 256, instruction memory words; PC wraps at MEM_DEPTH*4 bytes.
- RESET_PC, 0, byte address loaded on reset; must be word aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- fetch_en  in  1  fetch permitted this cycle.
- imem_addr  out  DATA_WIDTH  byte address to instruction memory; equals pc.
- imem_instr  in  DATA_WIDTH  instruction word; combinational response to imem_addr in the same cycle.
- redirect_valid  in  1  flush and load new PC.
- redirect_pc  in  DATA_WIDTH  redirect target; bits [1:0] ignored.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  DATA_WIDTH  byte PC of head instruction.
- out_instr  out  DATA_WIDTH  raw instruction word.
- out_opcode  out  5  out_instr[31:27].
- out_rd  out  5  out_instr[26:22].
- out_rs1  out  5  out_instr[21:17].
- out_rs2  out  5  out_instr[16:12].
- out_imm  out  DATA_WIDTH  out_instr[11:0] sign-extended.
- halted  out  1  fetch stopped by NOP detection; constant 0 when feature absent.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc=RESET_PC; buffer emptied; out_valid=0; halted=0.
  - Data outputs are 0 when the buffer is empty.
- Push condition: fetch_en=1, redirect_valid=0, halted=0, and (count<2 or pop this cycle).
- Pop condition: out_valid & out_ready.
- On push: entry {pc, imem_instr} is written to the buffer tail; pc <= pc+4.
- PC wrap: pc+4 wraps to 0 when pc == (MEM_DEPTH-1)*4. PC bits above $clog2(MEM_DEPTH)+1 are always 0.
- Latency: an instruction fetched in cycle N is visible at the outputs in cycle N+1. Throughput is 1 instruction/cycle with out_ready held high.
- Buffer:
  - 2-entry FIFO; count 0..2.
  - Simultaneous push and pop at count=2 is legal; count stays 2.
  - Push is never attempted at count=2 without a pop.
- Handshake:
  - out_valid = (count!=0).
  - While out_valid=1 and out_ready=0, head outputs stay stable.
  - out_valid is never withdrawn except by redirect or reset.
- Redirect (highest priority after reset):
  - Buffer flushed (count=0).
  - pc <= {redirect_pc[31:2], 2'b00}; halted <= 0.
  - No push that cycle; a pop in the same cycle is discarded.
  - First post-redirect instruction appears 2 cycles after the redirect edge.
- fetch_en=0: pc holds; buffer drains normally.
- Field slicing is purely combinational from the buffer head.

Optional Feature:
- Macro: IFU_HALT_ON_NOP_EN.
- Defined:
  - A pushed word equal to 32'h0 is still buffered and delivered.
  - halted <= 1 on the same edge; pc is not incremented.
  - Pushes stop until redirect or reset.
- Undefined:
  - NOP words are treated as ordinary instructions.
  - halted is tied to 0.

Decomposition:
- isa_pkg holds:
  - field bit positions;
  - OPCODE_W=5 and REG_W=5;
  - IMM_W=12;
  - NOP_WORD=32'h0;
  - opcode localparams ADD=0 .. PASS_A=15.
- Sub-module fetch_fifo: 2-entry synchronous FIFO of {pc, instr} with push/pop/flush and count output.

Test Plan:
- Reset, out_ready=1, fetch_en=1, memory word0=0x00443000:
  - cycle 1 gives out_pc=0, out_opcode=0, out_rd=1, out_rs1=2, out_rs2=3, out_imm=0;
  - subsequent cycles give out_pc=4, 8, 12 back-to-back.
- out_ready=0 for 5 cycles:
  - count saturates at 2 and pc stops at 8;
  - out_pc stays 0;
  - on release, pcs 0, 4, 8 delivered consecutively with no gap or duplicate.
- Fetch at pc=0x44 (word17=0x09CE0FFB): out_opcode=1, out_rd=7, out_rs1=7, out_imm=0xFFFFFFFB.
- redirect_valid with redirect_pc=0x43 while buffer is full:
  - flush, and out_valid=0 next cycle;
  - next delivered out_pc=0x40.
- Redirect to 0x3FC:
  - out_pc=0x3FC followed by out_pc=0x0 (wrap).
- IFU_HALT_ON_NOP_EN defined, run from 0:
  - word at 0x5C (all zero) is delivered;
  - halted=1 and pc holds at 0x5C;
  - redirect to 0 clears halted and fetch resumes.

Source files
------------

// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the fetch path.
// Includes field positions and widths, the NOP encoding, opcodes and an immediate sign-extend helper.
package isa_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 12;

  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_LSB     = 22;
  localparam int unsigned RS1_LSB    = 17;
  localparam int unsigned RS2_LSB    = 12;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [31:0] NOP_WORD = 32'h0;

  localparam logic [OPCODE_W-1:0] ADD    = 5'd0;
  localparam logic [OPCODE_W-1:0] SUB    = 5'd1;
  localparam logic [OPCODE_W-1:0] AND    = 5'd2;
  localparam logic [OPCODE_W-1:0] OR     = 5'd3;
  localparam logic [OPCODE_W-1:0] XOR    = 5'd4;
  localparam logic [OPCODE_W-1:0] SLL    = 5'd5;
  localparam logic [OPCODE_W-1:0] SRL    = 5'd6;
  localparam logic [OPCODE_W-1:0] SRA    = 5'd7;
  localparam logic [OPCODE_W-1:0] SLT    = 5'd8;
  localparam logic [OPCODE_W-1:0] SLTU   = 5'd9;
  localparam logic [OPCODE_W-1:0] LOAD   = 5'd10;
  localparam logic [OPCODE_W-1:0] STORE  = 5'd11;
  localparam logic [OPCODE_W-1:0] BEQ    = 5'd12;
  localparam logic [OPCODE_W-1:0] BNE    = 5'd13;
  localparam logic [OPCODE_W-1:0] JAL    = 5'd14;
  localparam logic [OPCODE_W-1:0] PASS_A = 5'd15;

  function automatic logic [31:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
    return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of {pc, instr} pairs with flush; head reads as zero when empty.
module fetch_fifo #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop;

  assign do_pop = pop_i & (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      // When full, push and pop hit the same slot; the head has moved on by then.
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push_i) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, buffers fetched words in a 2-entry FIFO and hands them to decode.
// Define IFU_HALT_ON_NOP_EN to stop fetching after an all-zero word until redirect or reset.
module instruction_fetch_unit
  import isa_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 256,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [OPCODE_W-1:0]   out_opcode,
  output logic [REG_W-1:0]      out_rd,
  output logic [REG_W-1:0]      out_rs1,
  output logic [REG_W-1:0]      out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  halted
);

  localparam int unsigned AddrBits = $clog2(MEM_DEPTH) + 2;
  localparam logic [DATA_WIDTH-1:0] PcMax  = DATA_WIDTH'((MEM_DEPTH - 1) * 4);
  // Word-aligned and confined to the memory's byte range.
  localparam logic [DATA_WIDTH-1:0] PcMask = DATA_WIDTH'((2 ** AddrBits) - 4);

  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [2*DATA_WIDTH-1:0] head;
  logic [1:0]              fifo_count;
  logic                    push, pop;
  logic                    fetch_blocked;
  logic                    nop_hold;

`ifdef IFU_HALT_ON_NOP_EN
  logic halted_q, halted_d;
  logic is_nop;

  assign is_nop = (imem_instr == NOP_WORD);

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = 1'b0;
    end else if (push && is_nop) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign fetch_blocked = halted_q;
  assign nop_hold      = push & is_nop;
  assign halted        = halted_q;
`else
  assign fetch_blocked = 1'b0;
  assign nop_hold      = 1'b0;
  assign halted        = 1'b0;
`endif

  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & ~fetch_blocked & ((fifo_count < 2'd2) | pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & PcMask;
    end else if (push && !nop_hold) begin
      pc_d = (pc_q == PcMax) ? '0 : pc_q + DATA_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .Width(2 * DATA_WIDTH)
  ) u_fetch_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(redirect_valid),
    .push_i (push),
    .pop_i  (pop),
    .data_i ({pc_q, imem_instr}),
    .data_o (head),
    .count_o(fifo_count)
  );

  assign imem_addr  = pc_q;
  assign out_valid  = (fifo_count != 2'd0);
  assign out_pc     = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_instr  = head[DATA_WIDTH-1:0];
  assign out_opcode = out_instr[OPCODE_LSB +: OPCODE_W];
  assign out_rd     = out_instr[RD_LSB +: REG_W];
  assign out_rs1    = out_instr[RS1_LSB +: REG_W];
  assign out_rs2    = out_instr[RS2_LSB +: REG_W];
  assign out_imm    = sign_ext_imm(out_instr[IMM_LSB +: IMM_W]);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// against a queue-based model of the fetch stream.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH = 256;
`ifdef IFU_HALT_ON_NOP_EN
  localparam bit HaltFeature = 1'b1;
`else
  localparam bit HaltFeature = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_instr, out_pc, out_instr, out_imm;
  logic [4:0]  out_opcode, out_rd, out_rs1, out_rs2;
  logic        out_valid, halted;

  logic [31:0] mem [DEPTH];
  assign imem_instr = mem[imem_addr[9:2]];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_opcode    (out_opcode),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .halted        (halted)
  );

  // Reference model: pending deliveries in order, next fetch address, halt flag.
  logic [63:0] m_q [$];
  int unsigned m_pc;
  bit          m_halted;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [31:0] exp_imm(input logic [31:0] w);
    int v;
    v = int'(w % 4096);
    if (v >= 2048) v = v - 4096;
    return 32'(v);
  endfunction

  // Drive one cycle of inputs, advance the model, then sample at the following negedge.
  task automatic drive(input bit rst, input bit fe, input bit rv, input logic [31:0] rpc,
                       input bit rdy);
    bit          pop, push;
    logic [31:0] w;
    rst_n          = !rst;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (rst) begin
      m_q.delete();
      m_pc     = 0;
      m_halted = 0;
    end else if (rv) begin
      m_q.delete();
      m_pc     = ((rpc % (DEPTH * 4)) / 4) * 4;
      m_halted = 0;
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      push = fe && !m_halted && ((m_q.size() < 2) || pop);
      w    = mem[m_pc / 4];
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({32'(m_pc), w});
        if (HaltFeature && w == 32'h0) m_halted = 1;
        else m_pc = (m_pc + 4) % (DEPTH * 4);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_halted: got %b want 0", halted);
    end
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want 0", imem_addr);
    end
    n_cmp++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_imm !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got pc %h instr %h imm %h want 0", out_pc, out_instr,
                         out_imm);
    end
  endtask

  task automatic test_stream();
    drive(0, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL stream_first: got v %b pc %h want v 1 pc 0", out_valid, out_pc);
    end
    n_cmp++;
    if (out_opcode !== 5'd0 || out_rd !== 5'd1 || out_rs1 !== 5'd2 || out_rs2 !== 5'd3
        || out_imm !== 32'h0) begin
      n_fail++; $display("FAIL stream_fields: got op %0d rd %0d rs1 %0d rs2 %0d imm %h want 0 1 2 3 0",
                         out_opcode, out_rd, out_rs1, out_rs2, out_imm);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL stream_pc%0d: got v %b pc %h want v 1 pc %h", i, out_valid,
                           out_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    drive(1, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_valid: got %b want 0", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
        n_fail++; $display("FAIL stall_head%0d: got v %b pc %h want v 1 pc 0", i, out_valid, out_pc);
      end
    end
    n_cmp++;
    if (imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL stall_pc: got %h want 8", imem_addr);
    end
    for (int i = 1; i <= 2; i++) begin
      drive(0, 1, 0, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL release_pc%0d: got v %b pc %h want v 1 pc %h", i, out_valid,
                           out_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_fields();
    drive(0, 1, 1, 32'h44, 1);
    drive(0, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h44) begin
      n_fail++; $display("FAIL fields_pc: got v %b pc %h want v 1 pc 44", out_valid, out_pc);
    end
    n_cmp++;
    if (out_opcode !== 5'd1 || out_rd !== 5'd7 || out_rs1 !== 5'd7 || out_imm !== 32'hFFFFFFFB)
    begin
      n_fail++; $display("FAIL fields_decode: got op %0d rd %0d rs1 %0d imm %h want 1 7 7 fffffffb",
                         out_opcode, out_rd, out_rs1, out_imm);
    end
  endtask

  task automatic test_redirect_flush();
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 32'h43, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    drive(0, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      n_fail++; $display("FAIL flush_target: got v %b pc %h want v 1 pc 40", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 1, 32'h3FC, 1);
    drive(0, 1, 0, 0, 1);
    n_cmp++;
    if (out_pc !== 32'h3FC) begin
      n_fail++; $display("FAIL wrap_last: got %h want 3fc", out_pc);
    end
    drive(0, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap_zero: got v %b pc %h want v 1 pc 0", out_valid, out_pc);
    end
  endtask

  task automatic test_halt();
    bit seen = 0;
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_pc == 32'h5C) seen = (out_instr == 32'h0);
      drive(0, 1, 0, 0, 1);
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL nop_delivered: got %b want 1", seen);
    end
    n_cmp++;
    if (halted !== HaltFeature) begin
      n_fail++; $display("FAIL nop_halted: got %b want %b", halted, HaltFeature);
    end
    n_cmp++;
    if (imem_addr !== (HaltFeature ? 32'h5C : 32'h78)) begin
      n_fail++; $display("FAIL nop_pc: got %h want %h", imem_addr,
                         HaltFeature ? 32'h5C : 32'h78);
    end
    drive(0, 0, 1, 32'h0, 1);
    n_cmp++;
    if (halted !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL nop_unhalt: got halted %b valid %b want 0 0", halted, out_valid);
    end
    drive(0, 1, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL nop_resume: got v %b pc %h want v 1 pc 0", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    logic [63:0] head;
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 3) != 0);
      head = (m_q.size() != 0) ? m_q[0] : 64'h0;
      w    = head[31:0];
      n_cmp++;
      if (out_valid !== (m_q.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", i, out_valid, m_q.size() != 0);
      end
      n_cmp++;
      if (out_pc !== head[63:32] || out_instr !== w) begin
        n_fail++; $display("FAIL rand_head@%0d: got %h/%h want %h/%h", i, out_pc, out_instr,
                           head[63:32], w);
      end
      n_cmp++;
      if (out_opcode !== 5'(w >> 27) || out_rd !== 5'(w >> 22) || out_rs1 !== 5'(w >> 17)
          || out_rs2 !== 5'(w >> 12) || out_imm !== exp_imm(w)) begin
        n_fail++; $display("FAIL rand_fields@%0d: got %0d %0d %0d %0d %h for word %h", i,
                           out_opcode, out_rd, out_rs1, out_rs2, out_imm, w);
      end
      n_cmp++;
      if (imem_addr !== 32'(m_pc) || halted !== m_halted) begin
        n_fail++; $display("FAIL rand_pc@%0d: got pc %h halted %b want %h %b", i, imem_addr,
                           halted, 32'(m_pc), m_halted);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'h0) mem[i] = 32'h1;
    end
    mem[0]  = 32'h00443000;
    mem[17] = 32'h09CE0FFB;
    mem[23] = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_fields();
    test_redirect_flush();
    test_wrap();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
